// File: rtl/clock_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clock_phase_scheduler
// Brief    : Locks onto a sampled slow clock and strobes a safe transfer slot.
// Revision : 1.0
// ============================================================================
module clock_phase_scheduler #(
  parameter int CNT_W        = 8,
  parameter int LOCK_PERIODS = 4,
  parameter int TOL          = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLK_VAL,
  input  logic             EN,
  input  logic [CNT_W-1:0] OFFSET,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] PHASE_CNT,
  output logic             XFER_STB,
  output logic             ERR
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_acq  = 2'd1;
  localparam logic [1:0] c_st_lock = 2'd2;
  localparam logic [3:0] c_lock_match = 4'(LOCK_PERIODS);
  localparam logic [CNT_W:0] c_tol = (CNT_W+1)'(TOL);

  logic [1:0]       r_state, w_state_nxt;
  logic             r_val_d;
  logic [CNT_W-1:0] r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [3:0]       r_match, w_match_nxt;
  logic             r_started, w_started_nxt;
  logic             r_err, w_set_err;

  logic             w_rise, w_sat, w_timeout, w_in_tol;
  logic [CNT_W:0]   w_meas, w_period_ext, w_diff;
  logic [CNT_W-1:0] w_meas_sat;

  assign w_rise       = CLK_VAL & ~r_val_d;
  assign w_sat        = (r_phase == {CNT_W{1'b1}});
  assign w_timeout    = w_sat & r_started & ~w_rise;
  assign w_meas       = {1'b0, r_phase} + {{CNT_W{1'b0}}, 1'b1};
  assign w_period_ext = {1'b0, r_period};
  assign w_diff       = (w_meas >= w_period_ext) ? (w_meas - w_period_ext)
                                                 : (w_period_ext - w_meas);
  assign w_in_tol     = (w_diff <= c_tol);
  // A measurement taken off a saturated counter clamps to the largest period.
  assign w_meas_sat   = w_meas[CNT_W] ? {CNT_W{1'b1}} : w_meas[CNT_W-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= c_st_idle;
      r_val_d   <= 1'b0;
      r_phase   <= '0;
      r_period  <= '0;
      r_match   <= '0;
      r_started <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_val_d   <= CLK_VAL;
      r_phase   <= w_phase_nxt;
      r_period  <= w_period_nxt;
      r_match   <= w_match_nxt;
      r_started <= w_started_nxt;
      if (w_set_err)
        r_err <= 1'b1;
      else if (CLR_ERR)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_period_nxt  = r_period;
    w_match_nxt   = r_match;
    w_started_nxt = r_started;
    w_set_err     = 1'b0;

    if (!EN || r_state == c_st_idle)
      w_phase_nxt = '0;
    else if (w_rise)
      w_phase_nxt = '0;
    else if (w_sat)
      w_phase_nxt = r_phase;
    else
      w_phase_nxt = r_phase + 1'b1;

    if (!EN) begin
      w_state_nxt   = c_st_idle;
      w_match_nxt   = '0;
      w_started_nxt = 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_state_nxt   = c_st_acq;
          w_match_nxt   = '0;
          w_started_nxt = 1'b0;
        end
        c_st_acq: begin
          if (w_rise) begin
            if (!r_started) begin
              w_started_nxt = 1'b1;
            end else begin
              if (r_match == 4'd0 || !w_in_tol) begin
                w_period_nxt = w_meas_sat;
                w_match_nxt  = 4'd1;
              end else begin
                w_match_nxt = r_match + 4'd1;
              end
              if (w_match_nxt == c_lock_match)
                w_state_nxt = c_st_lock;
            end
          end else if (w_timeout) begin
            w_started_nxt = 1'b0;
            w_match_nxt   = '0;
          end
        end
        c_st_lock: begin
          if (w_rise) begin
            if (!w_in_tol) begin
              w_state_nxt   = c_st_acq;
              w_started_nxt = 1'b1;
              w_match_nxt   = 4'd1;
              w_period_nxt  = w_meas_sat;
              w_set_err     = 1'b1;
            end
          end else if (w_timeout) begin
            w_state_nxt   = c_st_acq;
            w_started_nxt = 1'b0;
            w_match_nxt   = '0;
            w_set_err     = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = c_st_idle;
          w_match_nxt   = '0;
          w_started_nxt = 1'b0;
        end
      endcase
    end
  end

  // The strobe is dropped in any cycle that is about to leave LOCKED.
  always_comb begin
    LOCKED   = (r_state == c_st_lock);
    XFER_STB = LOCKED & (r_phase == OFFSET) & (OFFSET < r_period) & ~w_rise &
               (w_state_nxt == c_st_lock);
  end

  assign PERIOD    = r_period;
  assign PHASE_CNT = r_phase;
  assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clock_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_phase_scheduler
// Brief    : Directed vector bench for clock_phase_scheduler.
// Revision : 1.0
// ============================================================================
module tb_clock_phase_scheduler;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             CLK_VAL;
  logic             EN;
  logic [CNT_W-1:0] OFFSET;
  logic             CLR_ERR;
  logic             LOCKED;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] PHASE_CNT;
  logic             XFER_STB;
  logic             ERR;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int pa;          // even-indexed period length
    int pb;          // odd-indexed period length
    int n;           // periods applied before the checking rise
    int off;
    int exp_lock;
    int exp_period;
    int exp_stb;     // cycle index of strobe in following period, -2 = none
  } vec_t;

  vec_t vecs[9];

  clock_phase_scheduler #(.CNT_W(CNT_W), .LOCK_PERIODS(4), .TOL(1)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLK_VAL  (CLK_VAL),
    .EN       (EN),
    .OFFSET   (OFFSET),
    .CLR_ERR  (CLR_ERR),
    .LOCKED   (LOCKED),
    .PERIOD   (PERIOD),
    .PHASE_CNT(PHASE_CNT),
    .XFER_STB (XFER_STB),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fast cycle: drive CLK_VAL, optionally check the strobe, then clock.
  task automatic cyc(input logic v, input int stb);
    CLK_VAL = v;
    #1;
    if (stb >= 0) chk("xfer_stb", XFER_STB, stb);
    tick();
  endtask

  // Cycles from..p-1 of a slow period of p fast cycles; cycle 0 is the rise.
  task automatic run(input int p, input int from, input int stb_i);
    for (int i = from; i < p; i++)
      cyc(i < p / 2, (stb_i == -1) ? -1 : ((i == stb_i) ? 1 : 0));
  endtask

  task automatic do_reset();
    EN = 1'b0; CLK_VAL = 1'b0; CLR_ERR = 1'b0; OFFSET = '0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic acquire8(input int off);
    EN = 1'b1;
    OFFSET = CNT_W'(off);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    repeat (4) run(8, 0, -2);
    chk("pre_lock", LOCKED, 0);
    cyc(1'b1, 0);
    chk("lock_after_5th_rise", LOCKED, 1);
    chk("lock_period", PERIOD, 8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; EN = 1'b0; CLK_VAL = 1'b0; CLR_ERR = 1'b0; OFFSET = '0;

    vecs[0] = '{8,  8,  4, 3,  1, 8,  4};
    vecs[1] = '{8,  9,  4, 3,  1, 8,  4};
    vecs[2] = '{8,  10, 8, 3,  0, 10, -2};
    vecs[3] = '{9,  9,  4, 0,  1, 9,  1};
    vecs[4] = '{8,  9,  3, 3,  0, 8,  -2};
    vecs[5] = '{20, 20, 4, 19, 1, 20, -2};
    vecs[6] = '{8,  8,  4, 6,  1, 8,  7};
    vecs[7] = '{8,  8,  4, 9,  1, 8,  -2};
    vecs[8] = '{8,  8,  4, 8,  1, 8,  -2};

    do_reset();
    chk("rst_locked", LOCKED, 0);
    chk("rst_period", PERIOD, 0);
    chk("rst_phase", PHASE_CNT, 0);
    chk("rst_stb", XFER_STB, 0);
    chk("rst_err", ERR, 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      EN = 1'b1;
      OFFSET = CNT_W'(vecs[v].off);
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      for (int k = 0; k < vecs[v].n; k++)
        run((k % 2 == 1) ? vecs[v].pb : vecs[v].pa, 0, -2);
      cyc(1'b1, 0);
      chk($sformatf("vec%0d_locked", v), LOCKED, vecs[v].exp_lock);
      chk($sformatf("vec%0d_period", v), PERIOD, vecs[v].exp_period);
      chk($sformatf("vec%0d_err", v), ERR, 0);
      run((vecs[v].n % 2 == 1) ? vecs[v].pb : vecs[v].pa, 1, vecs[v].exp_stb);
    end

    // Strobe placement, out-of-range offset, period jump and relock.
    do_reset();
    acquire8(3);
    run(8, 1, 4);
    run(8, 0, 4);
    OFFSET = 8'd9;
    run(8, 0, -2);
    run(8, 0, -2);
    OFFSET = 8'd3;
    run(10, 0, 4);
    cyc(1'b1, 0);
    chk("jump_unlock", LOCKED, 0);
    chk("jump_err", ERR, 1);
    chk("jump_period", PERIOD, 10);
    run(10, 1, -2);
    run(10, 0, -2);
    run(10, 0, -2);
    chk("relock_pending", LOCKED, 0);
    cyc(1'b1, 0);
    chk("relock_10", LOCKED, 1);
    CLR_ERR = 1'b1;
    cyc(1'b1, 0);
    CLR_ERR = 1'b0;
    run(10, 2, 4);
    chk("clr_err", ERR, 0);
    run(9, 0, 4);
    cyc(1'b1, 0);
    chk("tol_stay_locked", LOCKED, 1);
    chk("tol_period_held", PERIOD, 10);
    chk("tol_no_err", ERR, 0);

    // Slow clock stops: saturation timeout.
    for (int k = 0; k < 300; k++) begin
      if (k == 255) begin
        chk("to_locked_at_255", LOCKED, 1);
        chk("to_phase_255", PHASE_CNT, 255);
      end
      if (k == 256) begin
        chk("to_unlocked", LOCKED, 0);
        chk("to_err", ERR, 1);
        chk("to_phase_sat", PHASE_CNT, 255);
      end
      cyc(1'b0, (k == 3) ? 1 : 0);
    end
    CLR_ERR = 1'b1;
    cyc(1'b0, 0);
    CLR_ERR = 1'b0;
    chk("to_clr_err", ERR, 0);
    repeat (4) run(8, 0, -2);
    cyc(1'b1, 0);
    chk("to_relock", LOCKED, 1);
    chk("to_relock_period", PERIOD, 8);
    run(8, 1, 4);
    run(12, 0, 4);
    CLR_ERR = 1'b1;
    cyc(1'b1, 0);
    CLR_ERR = 1'b0;
    chk("set_wins_err", ERR, 1);
    chk("set_wins_unlock", LOCKED, 0);
    chk("set_wins_period", PERIOD, 12);

    // Enable dropped mid-lock at the would-be strobe cycle.
    do_reset();
    acquire8(3);
    run(8, 1, 4);
    cyc(1'b1, 0);
    cyc(1'b1, 0);
    cyc(1'b1, 0);
    cyc(1'b1, 0);
    EN = 1'b0;
    cyc(1'b0, 0);
    chk("en_off_locked", LOCKED, 0);
    chk("en_off_phase", PHASE_CNT, 0);
    chk("en_off_period_held", PERIOD, 8);
    run(8, 5, -2);
    run(8, 0, -2);
    run(8, 0, -2);
    chk("en_off_phase_held", PHASE_CNT, 0);
    acquire8(3);
    run(8, 1, 4);

    // Asynchronous reset in the middle of a cycle.
    cyc(1'b1, 0);
    cyc(1'b1, 0);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_locked", LOCKED, 0);
    chk("async_period", PERIOD, 0);
    chk("async_phase", PHASE_CNT, 0);
    chk("async_stb", XFER_STB, 0);
    chk("async_err", ERR, 0);
    tick();
    RST_N = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_phase_scheduler.md
Name: clock_phase_scheduler

Overview:
- Fast-clock-domain controller that consumes the fast-sampled slow-clock level (CLK_VAL from the slow-clock sampling flop) and locks onto the slow-clock period.
- Once locked, issues a one-cycle transfer strobe at a programmable fast-cycle offset after each slow rising edge, so fast-side logic can hand data to the slow domain in a safe window.
- Detects loss of lock and reports it through a sticky error flag.

Parameters:
- CNT_W, 8, width of phase counter, period and offset (max measurable period 2^CNT_W-1)
- LOCK_PERIODS, 4, consecutive matching period measurements required to lock (1..15)
- TOL, 1, allowed absolute difference in fast cycles between a measurement and the reference period

Ports:
- CLK  in  1  fast clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- CLK_VAL  in  1  slow-clock level, already registered in the CLK domain
- EN  in  1  enable; low forces IDLE
- OFFSET  in  CNT_W  strobe position in fast cycles after a rise; quasi-static while LOCKED
- CLR_ERR  in  1  one-cycle pulse, clears ERR
- LOCKED  out  1  high in LOCKED state
- PERIOD  out  CNT_W  reference period in fast cycles; valid when LOCKED
- PHASE_CNT  out  CNT_W  fast cycles since last rise (0 on the cycle after the rise cycle)
- XFER_STB  out  1  transfer strobe
- ERR  out  1  sticky loss-of-lock / timeout flag

Behaviour:
- Reset (RST_N low, async): all registers 0. State IDLE, LOCKED=0, PERIOD=0, PHASE_CNT=0, XFER_STB=0, ERR=0, internal val_d=0, match count=0, started=0.
- Edge detect: val_d <= CLK_VAL each cycle. rise = CLK_VAL & ~val_d. "Rise cycle" is the cycle in which rise=1.
- Phase counter: on a rise cycle, PHASE_CNT <= 0. Otherwise PHASE_CNT <= PHASE_CNT+1, saturating at 2^CNT_W-1. Counter runs in every state except IDLE, where it is held at 0.
- Measurement: on a rise cycle with started=1, meas = PHASE_CNT+1, computed CNT_W+1 wide. Rises t and t+P give meas=P.
- States:
  - IDLE: on EN=1 go to ACQUIRE with started=0 and match=0.
  - ACQUIRE, first rise: sets started=1; no measurement.
  - ACQUIRE, later rises: if match=0 or |meas-PERIOD|>TOL, then PERIOD<=meas and match<=1. Otherwise match<=match+1 and PERIOD is unchanged.
  - ACQUIRE to LOCKED: when the updated match equals LOCK_PERIODS, LOCKED asserts the next cycle. With LOCK_PERIODS=1, the first measurement locks.
  - LOCKED, rise with |meas-PERIOD|<=TOL: stay LOCKED; PERIOD unchanged.
  - LOCKED, rise with |meas-PERIOD|>TOL: go to ACQUIRE with started=1, match=1, PERIOD<=meas; ERR<=1.
- Timeout: PHASE_CNT at saturation with started=1 and no rise.
  - In ACQUIRE: started<=0, match<=0.
  - In LOCKED: go to ACQUIRE with started=0, match=0; ERR<=1.
- EN low in any state: next cycle go to IDLE, with LOCKED=0, match=0, started=0, PHASE_CNT=0. PERIOD and ERR are held.
- XFER_STB = LOCKED & (PHASE_CNT==OFFSET) & ~rise.
  - No strobe if OFFSET >= PERIOD.
  - At most one strobe per slow period.
  - Suppressed in the cycle the block leaves LOCKED.
- ERR: set as above. CLR_ERR clears it. If set and clear occur in the same cycle, set wins.
- Simultaneous rise and saturation: the rise takes priority.

Test Plan:
- Slow period 8 fast cycles, EN=1, LOCK_PERIODS=4, TOL=1 -> LOCKED rises one cycle after the 5th rise cycle; PERIOD=8; ERR=0.
- Locked at 8, OFFSET=3 -> XFER_STB high exactly when PHASE_CNT=3, i.e. 4 cycles after each rise cycle; one pulse per period. OFFSET=9 -> no pulses.
- Locked at 8, then one period of 10 -> LOCKED drops one cycle after that rise; ERR=1; PERIOD=10; relock after 3 further periods of 10. Period 9 instead of 10 -> stays locked.
- Locked, CLK_VAL held low for 300 cycles (CNT_W=8) -> at PHASE_CNT=255, LOCKED=0 and ERR=1. CLR_ERR pulse -> ERR=0. CLR_ERR coincident with a new error -> ERR stays 1.
- Drop EN mid-lock -> IDLE next cycle; LOCKED=0, PHASE_CNT=0, no strobes. Re-enable -> relock after 5 rises.
- Assert RST_N low asynchronously mid-period -> all outputs 0 immediately. After release, jittered periods 8/9/8/9 lock (TOL=1) and 8/10/8/10 never lock.
